// File: rtl/rob_commit_scheduler.sv
// In-order retirement scheduler: allocates owner tags, records result-bus completions and
// retires up to COMMIT_W oldest contiguous completed entries per cycle onto the register-file port.
module rob_commit_scheduler #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 4,
  parameter int REG_W    = 4,
  parameter int DATA_W   = 16,
  parameter int COMMIT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  input  logic [REG_W-1:0]             alloc_target_reg,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic [COMMIT_W-1:0]          retirement_write_data_enable_flat,
  output logic [COMMIT_W*REG_W-1:0]    retirement_target_reg_flat,
  output logic [COMMIT_W*DATA_W-1:0]   retirement_write_data_flat,
  output logic [COMMIT_W*TAG_W-1:0]    instruction_writer_flat,
  output logic                         rob_empty
);

  localparam int CNT_W = TAG_W + 1;
  localparam int K_W   = $clog2(COMMIT_W + 1);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [REG_W-1:0]  target_q [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              alloc_fire;
  logic              cdb_fire;
  logic [K_W-1:0]    commit_k;
  logic [DEPTH-1:0]  commit_sel;
  logic [COMMIT_W-1:0] slot_take;
  logic [TAG_W-1:0]  slot_idx [COMMIT_W];

  // Allocation handshake and status come straight from the current state, so a slot
  // freed by this cycle's commit only becomes allocatable next cycle.
  assign alloc_ready = (count_q < CNT_W'(DEPTH));
  assign alloc_tag   = tail_q;
  assign rob_empty   = (count_q == '0);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cdb_fire    = cdb_valid && valid_q[cdb_tag];

  // Commit selection: contiguous run of valid&&done entries starting at head, capped at COMMIT_W.
  always_comb begin : commit_select
    logic run;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    run        = 1'b1;
    commit_k   = '0;
    commit_sel = '0;
    slot_take  = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      slot_idx[j] = head_q + TAG_W'(j);
      if (run && valid_q[slot_idx[j]] && done_q[slot_idx[j]]) begin
        commit_k                = commit_k + 1'b1;
        commit_sel[slot_idx[j]] = 1'b1;
        slot_take[j]            = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // process sees start-of-cycle values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + TAG_W'(commit_k);
      tail_q  <= tail_q + TAG_W'(alloc_fire);
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_k);
    end
  end

  // Per-entry flags. A committing entry is never the allocation target (tail is invalid
  // unless full, and allocation is blocked when full), so the ordering below is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_sel[i]) begin
          valid_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end
        if (alloc_fire && (tail_q == TAG_W'(i))) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
        end
        if (cdb_fire && !commit_sel[i] && (cdb_tag == TAG_W'(i))) begin
          done_q[i] <= 1'b1;
        end
      end
    end
  end

  // NOTE: the payload storage is deliberately not reset; it is only ever read while the
  // matching valid/done flags are set, and those flags are reset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (alloc_fire) begin
        target_q[tail_q] <= alloc_target_reg;
      end
      if (cdb_fire) begin
        data_q[cdb_tag] <= cdb_data;
      end
    end
  end

  // Registered retirement port: slot 0 (oldest) sits in the most significant field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retirement_write_data_enable_flat <= '0;
      retirement_target_reg_flat        <= '0;
      retirement_write_data_flat        <= '0;
      instruction_writer_flat           <= '0;
    end else if (flush) begin
      retirement_write_data_enable_flat <= '0;
      retirement_target_reg_flat        <= '0;
      retirement_write_data_flat        <= '0;
      instruction_writer_flat           <= '0;
    end else begin
      for (int j = 0; j < COMMIT_W; j++) begin
        retirement_write_data_enable_flat[COMMIT_W-1-j] <= slot_take[j];
        retirement_target_reg_flat[(COMMIT_W-1-j)*REG_W +: REG_W] <=
          slot_take[j] ? target_q[slot_idx[j]] : '0;
        retirement_write_data_flat[(COMMIT_W-1-j)*DATA_W +: DATA_W] <=
          slot_take[j] ? data_q[slot_idx[j]] : '0;
        instruction_writer_flat[(COMMIT_W-1-j)*TAG_W +: TAG_W] <=
          slot_take[j] ? slot_idx[j] : '0;
      end
    end
  end

endmodule
